// File: rtl/nmr_phase_pkg.sv
// Shared types and constants for the NMR phase-cycling logic.
// Phase codes are quarter turns: 0=0 deg, 1=90, 2=180, 3=270.
package nmr_phase_pkg;

    typedef logic [1:0] phase_t;

    // One table entry, packed as {tx, rx}
    typedef struct packed {
        phase_t tx;
        phase_t rx;
    } phase_pair_t;

    localparam phase_t PH_0   = 2'd0;
    localparam phase_t PH_90  = 2'd1;
    localparam phase_t PH_180 = 2'd2;
    localparam phase_t PH_270 = 2'd3;

    typedef enum logic [2:0] {
        PCC_IDLE    = 3'd0,
        PCC_LOAD    = 3'd1,
        PCC_ARMED   = 3'd2,
        PCC_SCAN    = 3'd3,
        PCC_ADVANCE = 3'd4
    } pcc_state_t;

    // Phase sum wraps naturally modulo a full turn
    function automatic phase_t phase_add(input phase_t a, input phase_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/phase_table.sv
// Phase-cycling table: DEPTH x 4-bit register file, one synchronous write
// port and one read port with registered (1-cycle) read data.
// Contents are deliberately not reset.
module phase_table #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [3:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [3:0]        rdata
);

    logic [3:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/phase_cycle_controller.sv
// Phase cycle controller: steps through the phase table one entry per scan,
// wrapping at the active length, and stops after the programmed scan count.
// Optional build macro PHASE_CYCLE_CYCLOPS_EN adds a CYCLOPS offset that is
// added to both phases and advances each time the table index wraps.
module phase_cycle_controller
    import nmr_phase_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SCAN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [3:0]        cfg_wdata,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [SCAN_W-1:0] n_scans,
    input  logic              start,
    input  logic              abort,
    input  logic              scan_start,
    input  logic              scan_done,
    output logic [1:0]        TX_phase,
    output logic [1:0]        RX_phase,
    output logic              phases_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] step_idx,
    output logic [SCAN_W-1:0] scan_count,
    output logic              seq_done
);

    localparam logic [2:0] S_IDLE    = PCC_IDLE;
    localparam logic [2:0] S_LOAD    = PCC_LOAD;
    localparam logic [2:0] S_ARMED   = PCC_ARMED;
    localparam logic [2:0] S_SCAN    = PCC_SCAN;
    localparam logic [2:0] S_ADVANCE = PCC_ADVANCE;

    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [ADDR_W:0]   LEN_MAX  = DEPTH;
    localparam logic [ADDR_W-1:0] IDX_ONE  = 1;
    localparam logic [SCAN_W-1:0] SCAN_ONE = 1;

    logic [2:0]        state_reg,      state_next;
    logic [ADDR_W-1:0] step_idx_reg,   step_idx_next;
    logic [SCAN_W-1:0] scan_count_reg, scan_count_next;
    logic [ADDR_W:0]   len_reg,        len_next;
    logic [SCAN_W-1:0] n_scans_reg,    n_scans_next;
    phase_t            tx_reg,         tx_next;
    phase_t            rx_reg,         rx_next;
    logic              valid_reg,      valid_next;
    logic              busy_reg,       busy_next;
    logic              seq_done_reg,   seq_done_next;
`ifdef PHASE_CYCLE_CYCLOPS_EN
    phase_t            cyc_k_reg,      cyc_k_next;
`endif

    logic [ADDR_W:0]   len_clamped;
    logic [3:0]        table_rdata;
    phase_pair_t       entry;
    logic              table_we;

    // Writes are only accepted while no run is in progress
    assign table_we = cfg_we & ~busy_reg;
    assign entry    = table_rdata;

    // The read address tracks the next index so that the entry is already
    // on the read port during LOAD and can be registered onto the outputs
    // at the end of that cycle.
    phase_table #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_table (
        .clk   (clk),
        .we    (table_we),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (step_idx_next),
        .rdata (table_rdata)
    );

    // Active length: zero behaves as one, oversize values saturate at DEPTH
    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LEN_ONE;
        end else if (cfg_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    // Next-state and datapath decisions; abort overrides everything
    always_comb begin
        state_next      = state_reg;
        step_idx_next   = step_idx_reg;
        scan_count_next = scan_count_reg;
        len_next        = len_reg;
        n_scans_next    = n_scans_reg;
        tx_next         = tx_reg;
        rx_next         = rx_reg;
        valid_next      = valid_reg;
        seq_done_next   = 1'b0;
`ifdef PHASE_CYCLE_CYCLOPS_EN
        cyc_k_next      = cyc_k_reg;
`endif
        if (abort) begin
            state_next = S_IDLE;
            valid_next = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (n_scans == '0) begin
                            seq_done_next = 1'b1;
                        end else begin
                            len_next        = len_clamped;
                            n_scans_next    = n_scans;
                            step_idx_next   = '0;
                            scan_count_next = '0;
`ifdef PHASE_CYCLE_CYCLOPS_EN
                            cyc_k_next      = PH_0;
`endif
                            state_next      = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
`ifdef PHASE_CYCLE_CYCLOPS_EN
                    tx_next = phase_add(entry.tx, cyc_k_reg);
                    rx_next = phase_add(entry.rx, cyc_k_reg);
`else
                    tx_next = entry.tx;
                    rx_next = entry.rx;
`endif
                    valid_next = 1'b1;
                    state_next = S_ARMED;
                end
                S_ARMED: begin
                    if (scan_start) begin
                        state_next = S_SCAN;
                    end
                end
                S_SCAN: begin
                    // scan_done wins over a coincident scan_start here
                    if (scan_done) begin
                        scan_count_next = scan_count_reg + SCAN_ONE;
                        valid_next      = 1'b0;
                        if (scan_count_next == n_scans_reg) begin
                            seq_done_next = 1'b1;
                            state_next    = S_IDLE;
                        end else begin
                            state_next = S_ADVANCE;
                        end
                    end
                end
                S_ADVANCE: begin
                    if (({1'b0, step_idx_reg} + LEN_ONE) == len_reg) begin
                        step_idx_next = '0;
`ifdef PHASE_CYCLE_CYCLOPS_EN
                        cyc_k_next    = phase_add(cyc_k_reg, PH_90);
`endif
                    end else begin
                        step_idx_next = step_idx_reg + IDX_ONE;
                    end
                    state_next = S_LOAD;
                end
                default: begin
                    state_next = S_IDLE;
                    valid_next = 1'b0;
                end
            endcase
        end
        busy_next = (state_next != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            step_idx_reg   <= '0;
            scan_count_reg <= '0;
            len_reg        <= LEN_ONE;
            n_scans_reg    <= '0;
            tx_reg         <= PH_0;
            rx_reg         <= PH_0;
            valid_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            seq_done_reg   <= 1'b0;
`ifdef PHASE_CYCLE_CYCLOPS_EN
            cyc_k_reg      <= PH_0;
`endif
        end else begin
            state_reg      <= state_next;
            step_idx_reg   <= step_idx_next;
            scan_count_reg <= scan_count_next;
            len_reg        <= len_next;
            n_scans_reg    <= n_scans_next;
            tx_reg         <= tx_next;
            rx_reg         <= rx_next;
            valid_reg      <= valid_next;
            busy_reg       <= busy_next;
            seq_done_reg   <= seq_done_next;
`ifdef PHASE_CYCLE_CYCLOPS_EN
            cyc_k_reg      <= cyc_k_next;
`endif
        end
    end

    assign TX_phase     = tx_reg;
    assign RX_phase     = rx_reg;
    assign phases_valid = valid_reg;
    assign busy         = busy_reg;
    assign step_idx     = step_idx_reg;
    assign scan_count   = scan_count_reg;
    assign seq_done     = seq_done_reg;

endmodule

// File: tb/tb_phase_cycle_controller.sv
// Directed bench for phase_cycle_controller. Expected phase pairs are queued
// when a run is started and popped as each entry is presented.
// Expectations follow PHASE_CYCLE_CYCLOPS_EN when it is defined.
module tb_phase_cycle_controller;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int SCAN_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [3:0]        cfg_wdata;
    logic [ADDR_W:0]   cfg_len;
    logic [SCAN_W-1:0] n_scans;
    logic              start;
    logic              abort;
    logic              scan_start;
    logic              scan_done;
    logic [1:0]        TX_phase;
    logic [1:0]        RX_phase;
    logic              phases_valid;
    logic              busy;
    logic [ADDR_W-1:0] step_idx;
    logic [SCAN_W-1:0] scan_count;
    logic              seq_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] sb_q[$];

    phase_cycle_controller #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .SCAN_W (SCAN_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_len      (cfg_len),
        .n_scans      (n_scans),
        .start        (start),
        .abort        (abort),
        .scan_start   (scan_start),
        .scan_done    (scan_done),
        .TX_phase     (TX_phase),
        .RX_phase     (RX_phase),
        .phases_valid (phases_valid),
        .busy         (busy),
        .step_idx     (step_idx),
        .scan_count   (scan_count),
        .seq_done     (seq_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [3:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic start_run(input logic [ADDR_W:0] len, input logic [SCAN_W-1:0] n);
        cfg_len = len;
        n_scans = n;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Bounded wait for phases_valid; an expired bound shows up as a failed check
    task automatic wait_valid();
        int n = 0;
        while (phases_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("valid_wait", {31'd0, phases_valid}, 32'd1);
    endtask

    // Compare the presented pair against the scoreboard head
    task automatic pop_check(input string tag);
        logic [3:0] exp;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_pair"}, {28'd0, TX_phase, RX_phase}, {28'd0, exp});
        end
    endtask

    // One full scan from ARMED: scan_start, scan_done, then latency checks
    task automatic do_scan(input string tag, input bit last);
        wait_valid();
        pop_check(tag);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check({tag, "_valid_in_scan"}, {31'd0, phases_valid}, 32'd1);
        scan_done = 1'b1;
        tick();
        scan_done = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, phases_valid}, 32'd0);
        if (last) begin
            check({tag, "_seq_done"}, {31'd0, seq_done}, 32'd1);
            check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
            tick();
            check({tag, "_seq_done_pulse"}, {31'd0, seq_done}, 32'd0);
        end else begin
            check({tag, "_no_seq_done"}, {31'd0, seq_done}, 32'd0);
            tick();
            check({tag, "_valid_t2"}, {31'd0, phases_valid}, 32'd0);
            tick();
            check({tag, "_valid_t3"}, {31'd0, phases_valid}, 32'd1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        cfg_len    = '0;
        n_scans    = '0;
        start      = 1'b0;
        abort      = 1'b0;
        scan_start = 1'b0;
        scan_done  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset values
        check("rst_tx",    {30'd0, TX_phase}, 32'd0);
        check("rst_rx",    {30'd0, RX_phase}, 32'd0);
        check("rst_valid", {31'd0, phases_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_step",  {28'd0, step_idx}, 32'd0);
        check("rst_count", {16'd0, scan_count}, 32'd0);
        check("rst_done",  {31'd0, seq_done}, 32'd0);

        // Table {i,i} for 0..3, distinct filler beyond the active length
        for (int i = 0; i < 4; i++) wr(4'(i), {2'(i), 2'(i)});
        for (int i = 4; i < DEPTH; i++) wr(4'(i), 4'b0110);

        // Main run: len=4, 6 scans
        sb_q.push_back(4'h0);
        sb_q.push_back(4'h5);
        sb_q.push_back(4'hA);
        sb_q.push_back(4'hF);
`ifdef PHASE_CYCLE_CYCLOPS_EN
        sb_q.push_back(4'h5);
        sb_q.push_back(4'hA);
`else
        sb_q.push_back(4'h0);
        sb_q.push_back(4'h5);
`endif
        start_run(5'd4, 16'd6);
        check("load_busy",  {31'd0, busy}, 32'd1);
        check("load_valid", {31'd0, phases_valid}, 32'd0);
        scan_start = 1'b1;              // must be ignored in LOAD
        tick();
        scan_start = 1'b0;
        check("valid_at_t2", {31'd0, phases_valid}, 32'd1);
        scan_done = 1'b1;               // ignored in ARMED: no scan was started
        tick();
        scan_done = 1'b0;
        check("armed_ignore_done_cnt",   {16'd0, scan_count}, 32'd0);
        check("armed_ignore_done_valid", {31'd0, phases_valid}, 32'd1);
        for (int i = 0; i < 6; i++) do_scan("main", i == 5);
        check("main_count", {16'd0, scan_count}, 32'd6);
        check("main_step",  {28'd0, step_idx}, 32'd1);

        // Abort together with start while in SCAN at scan_count=3
        sb_q.push_back(4'h0);
        sb_q.push_back(4'h5);
        sb_q.push_back(4'hA);
        sb_q.push_back(4'hF);
        start_run(5'd4, 16'd10);
        for (int i = 0; i < 3; i++) do_scan("abrt", 1'b0);
        wait_valid();
        pop_check("abrt4");
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_valid", {31'd0, phases_valid}, 32'd0);
        check("abort_busy",  {31'd0, busy}, 32'd0);
        check("abort_done",  {31'd0, seq_done}, 32'd0);
        check("abort_count", {16'd0, scan_count}, 32'd3);
        check("abort_step",  {28'd0, step_idx}, 32'd3);
        tick();
        check("abort_stay_idle", {31'd0, busy}, 32'd0);
        check("abort_no_done",   {31'd0, seq_done}, 32'd0);

        // n_scans=0: immediate completion pulse, never busy
        start_run(5'd4, 16'd0);
        check("n0_done", {31'd0, seq_done}, 32'd1);
        check("n0_busy", {31'd0, busy}, 32'd0);
        tick();
        check("n0_done_pulse", {31'd0, seq_done}, 32'd0);
        check("n0_busy2",      {31'd0, busy}, 32'd0);

        // cfg_len=0 behaves as length 1; a write while busy is dropped
`ifdef PHASE_CYCLE_CYCLOPS_EN
        sb_q.push_back(4'h0);
        sb_q.push_back(4'h5);
        sb_q.push_back(4'hA);
`else
        sb_q.push_back(4'h0);
        sb_q.push_back(4'h0);
        sb_q.push_back(4'h0);
`endif
        start_run(5'd0, 16'd3);
        wait_valid();
        wr(4'd0, 4'hF);
        for (int i = 0; i < 3; i++) do_scan("len0", i == 2);
        check("len0_count", {16'd0, scan_count}, 32'd3);

        // Two-entry table {0,2},{2,0}
        wr(4'd0, 4'b0010);
        wr(4'd1, 4'b1000);
        sb_q.push_back(4'b0010);
        sb_q.push_back(4'b1000);
`ifdef PHASE_CYCLE_CYCLOPS_EN
        sb_q.push_back(4'b0111);
        sb_q.push_back(4'b1101);
`else
        sb_q.push_back(4'b0010);
        sb_q.push_back(4'b1000);
`endif
        start_run(5'd2, 16'd4);
        for (int i = 0; i < 4; i++) do_scan("len2", i == 3);
        check("len2_count", {16'd0, scan_count}, 32'd4);

        // Reset pulse mid-SCAN clears outputs without waiting for a clock
        start_run(5'd2, 16'd5);
        wait_valid();
        check("pre_rst_rx", {30'd0, RX_phase}, 32'd2);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        rst_n = 1'b0;
        #2;
        check("arst_tx",    {30'd0, TX_phase}, 32'd0);
        check("arst_rx",    {30'd0, RX_phase}, 32'd0);
        check("arst_valid", {31'd0, phases_valid}, 32'd0);
        check("arst_busy",  {31'd0, busy}, 32'd0);
        check("arst_step",  {28'd0, step_idx}, 32'd0);
        check("arst_count", {16'd0, scan_count}, 32'd0);
        check("arst_done",  {31'd0, seq_done}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
